// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: register offsets, STATUS bit positions and receiver state
// encoding shared by the UART receiver slice.
package uart_rx_pkg;

  localparam logic [7:0] REG_STATUS = 8'h00;
  localparam logic [7:0] REG_POP    = 8'h01;
  localparam logic [7:0] REG_CLEAR  = 8'h02;

  localparam int ST_NE   = 8;
  localparam int ST_FULL = 9;
  localparam int ST_OVR  = 10;
  localparam int ST_FERR = 11;
  localparam int ST_PERR = 12;

  // Bit positions in the CLEAR write data
  localparam int CLR_OVR  = 0;
  localparam int CLR_FERR = 1;
  localparam int CLR_PERR = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: peripheral bus (ADDRESS/DATA_IN/DATA_OUT/WRb) for the 0x13xx window.
interface uart_rx_if #(parameter int BITS = 16);
  logic [7:0]      ADDRESS;
  logic [BITS-1:0] DATA_IN;
  logic [BITS-1:0] DATA_OUT;
  logic            WRb;

  modport master (output ADDRESS, DATA_IN, WRb, input DATA_OUT);
  modport slave  (input ADDRESS, DATA_IN, WRb, output DATA_OUT);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with first-word-fall-through head output.
// A push into a full FIFO is accepted only when a pop frees the slot in the
// same cycle; otherwise it is dropped and flagged on 'drop'.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage is not reset; the reader masks the head while empty
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with receive FIFO (window 0x13xx).
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and enables PERR.
module uart_rx #(
  parameter int CLK_FREQ   = 10000000,
  parameter int BAUD_RATE  = 115200,
  parameter int BITS       = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic     CLK,
  input  logic     RSTb,
  uart_rx_if.slave bus,
  input  logic     RX,
  output logic     RX_AVAIL
);
  import uart_rx_pkg::*;

  localparam int CPB  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  logic [1:0]  rx_sync;
  logic        rxs;
  rx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_ok;
  logic        push, ferr_evt, perr_evt;
  logic        ovr_q, ferr_q, perr_q;
  logic        wr_pop, wr_clr;
  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_empty, fifo_drop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [15:0] status;
  logic        unused_bits;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], RX};
  end
  assign rxs = rx_sync[1];

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;

  // Captured parity bit
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) par_q <= 1'b0;
    else       par_q <= par_d;
  end

  // Even parity over data plus parity bit must come out 0
  assign par_ok = ~^{sh_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // Receiver state and datapath registers
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Frame sequencing: the start bit is re-checked at half a bit, after which
  // every sample lands mid-bit by counting whole bit periods.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    push     = 1'b0;
    ferr_evt = 1'b0;
    perr_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d = '0;
          sh_d  = {rxs, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
            if (par_ok) push = 1'b1;
            else        perr_evt = 1'b1;
          end else begin
            ferr_evt = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        // Held-low line: FERR was raised once on entry, wait for idle
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_pop = ~bus.WRb & (bus.ADDRESS == REG_POP);
  assign wr_clr = ~bus.WRb & (bus.ADDRESS == REG_CLEAR);

  uart_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RSTb  (RSTb),
    .push  (push),
    .pop   (wr_pop),
    .din   (sh_q),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .count (fifo_count)
  );

  // Sticky error flags; a new event wins over a same-cycle clear
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= fifo_drop | (ovr_q  & ~(wr_clr & bus.DATA_IN[CLR_OVR]));
      ferr_q <= ferr_evt  | (ferr_q & ~(wr_clr & bus.DATA_IN[CLR_FERR]));
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity error flag
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) perr_q <= 1'b0;
    else       perr_q <= perr_evt | (perr_q & ~(wr_clr & bus.DATA_IN[CLR_PERR]));
  end
`else
  assign perr_q = 1'b0;
`endif

  // STATUS word; head is masked so an empty FIFO reads 0
  always_comb begin
    status          = '0;
    status[7:0]     = fifo_empty ? 8'h00 : fifo_head;
    status[ST_NE]   = ~fifo_empty;
    status[ST_FULL] = fifo_full;
    status[ST_OVR]  = ovr_q;
    status[ST_FERR] = ferr_q;
    status[ST_PERR] = perr_q;
  end

  assign bus.DATA_OUT = (bus.ADDRESS == REG_STATUS) ? BITS'(status) : '0;
  assign RX_AVAIL     = ~fifo_empty;

  assign unused_bits = ^{bus.DATA_IN, fifo_count, perr_evt};

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CLK_FREQ   = 1600;
  localparam int BAUD_RATE  = 100;
  localparam int BITS       = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int CPB        = 16;

  logic CLK  = 1'b0;
  logic RSTb = 1'b0;
  logic RX   = 1'b1;
  logic RX_AVAIL;

  uart_rx_if #(.BITS(BITS)) bus();

  uart_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .BITS(BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .bus(bus), .RX(RX), .RX_AVAIL(RX_AVAIL)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;
  int ferr_pulses = 0;
  logic [7:0] exp_q[$];
  logic ovr_m = 1'b0;

  always @(posedge CLK) if (dut.ferr_evt === 1'b1) ferr_pulses++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] exp_status(input int cnt, input logic ovr,
                                             input logic ferr, input logic perr);
    logic [15:0] s;
    s = '0;
    if (cnt > 0) begin
      s[7:0] = exp_q[0];
      s[8]   = 1'b1;
    end
    s[9]  = (cnt == FIFO_DEPTH);
    s[10] = ovr;
    s[11] = ferr;
    s[12] = perr;
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    @(negedge CLK);
    bus.ADDRESS = a;
    #1;
    d = bus.DATA_OUT;
    bus.ADDRESS = REG_STATUS;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge CLK);
    bus.ADDRESS = a;
    bus.DATA_IN = d;
    bus.WRb     = 1'b0;
    @(negedge CLK);
    bus.WRb     = 1'b1;
    bus.ADDRESS = REG_STATUS;
    bus.DATA_IN = '0;
  endtask

  // Serial frame; the line is left at the stop-bit level afterwards
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    @(negedge CLK);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (CPB) @(negedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    RX = par;
    repeat (CPB) @(negedge CLK);
    RX = stop;
`else
    RX = stop | (par & 1'b0);
`endif
    repeat (CPB) @(negedge CLK);
  endtask

  // Valid frame plus scoreboard update
  task automatic send_good(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
    else ovr_m = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] st;
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL reset_status got %h exp %h", st, 16'h0000); else n_pass++;
    n_total++; if (RX_AVAIL !== 1'b0) $display("FAIL reset_avail got %b exp 0", RX_AVAIL); else n_pass++;
    n_total++; if (dut.state_q !== IDLE) $display("FAIL reset_state got %0d exp %0d", dut.state_q, IDLE); else n_pass++;
  endtask

  task automatic test_basic();
    logic [15:0] st, e;
    send_good(8'hA5);
    idle(4);
    e = exp_status(exp_q.size(), 1'b0, 1'b0, 1'b0);
    rd(REG_STATUS, st);
    n_total++; if (st !== e || st !== 16'h01A5) $display("FAIL basic_status got %h exp %h", st, e); else n_pass++;
    n_total++; if (RX_AVAIL !== 1'b1) $display("FAIL basic_avail got %b exp 1", RX_AVAIL); else n_pass++;
    rd(REG_POP, st);
    n_total++; if (st !== 16'h0000) $display("FAIL read_pop_reg got %h exp 0000", st); else n_pass++;
    rd(REG_CLEAR, st);
    n_total++; if (st !== 16'h0000) $display("FAIL read_clear_reg got %h exp 0000", st); else n_pass++;
    rd(8'h7F, st);
    n_total++; if (st !== 16'h0000) $display("FAIL read_unmapped got %h exp 0000", st); else n_pass++;
    wr(8'h40, 16'hFFFF);
    rd(REG_STATUS, st);
    n_total++; if (st !== e) $display("FAIL unmapped_write got %h exp %h", st, e); else n_pass++;
    wr(REG_POP, 16'h0000);
    void'(exp_q.pop_front());
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL basic_after_pop got %h exp 0000", st); else n_pass++;
    n_total++; if (RX_AVAIL !== 1'b0) $display("FAIL basic_avail_after_pop got %b exp 0", RX_AVAIL); else n_pass++;
    wr(REG_POP, 16'h0000);
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL pop_empty got %h exp 0000", st); else n_pass++;
  endtask

  task automatic test_glitch();
    logic [15:0] st;
    @(negedge CLK);
    RX = 1'b0;
    idle(6);
    RX = 1'b1;
    idle(40);
    n_total++; if (dut.state_q !== IDLE) $display("FAIL glitch_state got %0d exp %0d", dut.state_q, IDLE); else n_pass++;
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL glitch_status got %h exp 0000", st); else n_pass++;
    send_good(8'h5A);
    idle(4);
    rd(REG_STATUS, st);
    n_total++; if (st !== exp_status(exp_q.size(), 1'b0, 1'b0, 1'b0)) $display("FAIL glitch_next_frame got %h exp %h", st, exp_status(exp_q.size(), 1'b0, 1'b0, 1'b0)); else n_pass++;
    wr(REG_POP, 16'h0000);
    void'(exp_q.pop_front());
  endtask

  task automatic test_ferr();
    logic [15:0] st;
    int p0;
    p0 = ferr_pulses;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    idle(40 * CPB);
    RX = 1'b1;
    idle(8);
    n_total++; if (ferr_pulses - p0 !== 1) $display("FAIL ferr_once got %0d exp 1", ferr_pulses - p0); else n_pass++;
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0800) $display("FAIL ferr_status got %h exp 0800", st); else n_pass++;
    wr(REG_CLEAR, 16'h0002);
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL ferr_clear got %h exp 0000", st); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [15:0] st, e;
    for (int i = 0; i <= 16; i++) send_good(8'(i));
    idle(4);
    e = exp_status(exp_q.size(), ovr_m, 1'b0, 1'b0);
    rd(REG_STATUS, st);
    n_total++; if (st !== e || st !== 16'h0700) $display("FAIL ovr_status got %h exp %h", st, e); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      rd(REG_STATUS, st);
      n_total++; if (st[7:0] !== exp_q[0]) $display("FAIL ovr_drain[%0d] got %h exp %h", i, st[7:0], exp_q[0]); else n_pass++;
      wr(REG_POP, 16'h0000);
      void'(exp_q.pop_front());
    end
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0400) $display("FAIL ovr_empty got %h exp 0400", st); else n_pass++;
    wr(REG_CLEAR, 16'h0001);
    ovr_m = 1'b0;
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL ovr_clear got %h exp 0000", st); else n_pass++;
  endtask

  task automatic test_push_pop_full();
    logic [15:0] st, e;
    logic hit;
    for (int i = 0; i < 16; i++) send_good(8'h20 + 8'(i));
    hit = 1'b0;
    fork
      send_frame(8'h30, ^8'h30, 1'b1);
      begin
        for (int c = 0; c < 400 && !hit; c++) begin
          @(negedge CLK);
          if (dut.push === 1'b1) hit = 1'b1;
        end
        if (hit) begin
          bus.ADDRESS = REG_POP;
          bus.WRb     = 1'b0;
          @(negedge CLK);
          bus.WRb     = 1'b1;
          bus.ADDRESS = REG_STATUS;
        end
      end
    join
    n_total++; if (hit !== 1'b1) $display("FAIL simul_push_seen got %b exp 1", hit); else n_pass++;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h30);
    idle(4);
    e = exp_status(exp_q.size(), 1'b0, 1'b0, 1'b0);
    rd(REG_STATUS, st);
    n_total++; if (st !== e || st !== 16'h0321) $display("FAIL simul_status got %h exp %h", st, e); else n_pass++;
    n_total++; if (dut.u_fifo.count !== 5'd16) $display("FAIL simul_count got %0d exp 16", dut.u_fifo.count); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      rd(REG_STATUS, st);
      n_total++; if (st[7:0] !== exp_q[0]) $display("FAIL simul_drain[%0d] got %h exp %h", i, st[7:0], exp_q[0]); else n_pass++;
      wr(REG_POP, 16'h0000);
      void'(exp_q.pop_front());
    end
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL simul_end got %h exp 0000", st); else n_pass++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [15:0] st;
    send_frame(8'h07, 1'b1, 1'b1);
    exp_q.push_back(8'h07);
    idle(4);
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0107) $display("FAIL par_good got %h exp 0107", st); else n_pass++;
    wr(REG_POP, 16'h0000);
    void'(exp_q.pop_front());
    send_frame(8'h07, 1'b0, 1'b1);
    idle(4);
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h1000) $display("FAIL par_bad got %h exp 1000", st); else n_pass++;
    wr(REG_CLEAR, 16'h0004);
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL par_clear got %h exp 0000", st); else n_pass++;
  endtask
`endif

  task automatic test_reset_midframe();
    logic [15:0] st;
    send_good(8'h11);
    idle(4);
    @(negedge CLK);
    RX = 1'b0;
    idle(3 * CPB);
    RSTb = 1'b0;
    #1;
    exp_q.delete();
    n_total++; if (dut.state_q !== IDLE) $display("FAIL rst_mid_state got %0d exp %0d", dut.state_q, IDLE); else n_pass++;
    n_total++; if (RX_AVAIL !== 1'b0) $display("FAIL rst_mid_avail got %b exp 0", RX_AVAIL); else n_pass++;
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL rst_mid_status got %h exp 0000", st); else n_pass++;
    RX = 1'b1;
    idle(2);
    RSTb = 1'b1;
    idle(4);
    rd(REG_STATUS, st);
    n_total++; if (st !== 16'h0000) $display("FAIL rst_mid_release got %h exp 0000", st); else n_pass++;
  endtask

  initial begin
    bus.ADDRESS = REG_STATUS;
    bus.DATA_IN = '0;
    bus.WRb     = 1'b1;
    idle(3);
    test_reset();
    RSTb = 1'b1;
    idle(4);
    test_reset();
    test_basic();
    test_glitch();
    test_ferr();
    test_overflow();
    test_push_pop_full();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
